elastic_pipe_chain: RTL and testbench

//  Parametrised multi-stage pipeline register for the pipelined CPU datapath.

---
 rtl/cpu_pipe_pkg.sv | 9 +
 rtl/pipe_stage_slot.sv | 28 ++
 rtl/elastic_pipe_chain.sv | 89 ++++++++
 tb/tb_elastic_pipe_chain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants and helpers for the CPU pipeline register chain.
package cpu_pipe_pkg;
  localparam int DATA_W = 64;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage: a valid flop plus a data register that only loads on a valid incoming beat.
module pipe_stage_slot
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vout <= 1'b0;
      dout <= RESET_VAL;
    end else if (adv) begin
      vout <= vin;
      // Bubbles leave the old data in place so idle stages do not toggle.
      if (vin) dout <= din;
    end
  end

endmodule

// File: rtl/elastic_pipe_chain.sv
// DEPTH-stage elastic pipeline register with per-stage valid, bubble collapse and synchronous flush.
module elastic_pipe_chain
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2_cnt(DEPTH)-1:0]  count
);

  localparam int CW = clog2_cnt(DEPTH);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("elastic_pipe_chain: DEPTH must be >= 1");
    end
  endgenerate

  // Handshake: a beat moves across a boundary on a rising edge where valid and
  // ready are both high; valid never depends on ready, ready may depend on valid.
  logic [DEPTH:0]   adv;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic             accept;
  logic             take;

  // A stage may advance if it is empty or the stage after it advances.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = ~valid[k] | adv[k+1];
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign take      = out_valid & out_ready;

  // Flush forces every slot to load a bubble; data registers keep their value.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      if (k == 0) begin : g_head
        pipe_stage_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slot (
          .clk   (clk),
          .reset (reset),
          .adv   (adv[k] | flush),
          .vin   (accept),
          .din   (in_data),
          .vout  (valid[k]),
          .dout  (data[k])
        );
      end else begin : g_body
        pipe_stage_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slot (
          .clk   (clk),
          .reset (reset),
          .adv   (adv[k] | flush),
          .vin   (valid[k-1] & ~flush),
          .din   (data[k-1]),
          .vout  (valid[k]),
          .dout  (data[k])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(accept) - CW'(take);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain at DEPTH 2 (main), 1 and 4, with a shared scoreboard monitor.
module tb_elastic_pipe_chain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        ir2, ov2, ir1, ov1, ir4, ov4;
  logic [63:0] od2, od1, od4;
  logic [1:0]  c2;
  logic [0:0]  c1;
  logic [2:0]  c4;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[3][$];

  // clock / reset block
  always #50 clk = ~clk;

  elastic_pipe_chain #(.WIDTH(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(c2)
  );
  elastic_pipe_chain #(.WIDTH(64), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(c1)
  );
  elastic_pipe_chain #(.WIDTH(64), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(c4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard: occupancy, in_ready and output ordering against the expected queue
  task automatic mon(input int i, input int depth, input int cnt, input logic irdy,
                     input logic ov, input logic [63:0] od);
    chk($sformatf("d%0d_count", depth), 64'(cnt), 64'(exp_q[i].size()));
    chk($sformatf("d%0d_in_ready", depth), 64'(irdy),
        64'(!flush && ((exp_q[i].size() < depth) || out_ready)));
    if (ov) begin
      chk($sformatf("d%0d_out_occupied", depth), 64'(exp_q[i].size() != 0), 64'd1);
      if (exp_q[i].size() != 0) begin
        chk($sformatf("d%0d_out_data", depth), od, exp_q[i][0]);
        if (out_ready) void'(exp_q[i].pop_front());
      end
    end
    if (flush) exp_q[i].delete();
    else if (in_valid && irdy) exp_q[i].push_back(in_data);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) exp_q[i].delete();
    end else begin
      mon(0, 2, int'(c2), ir2, ov2, od2);
      mon(1, 1, int'(c1), ir1, ov1, od1);
      mon(2, 4, int'(c4), ir4, ov4, od4);
    end
  end

  // Expects in_valid/in_data already driven for one beat into empty chains.
  task automatic measure_latency(input string tag, input logic [63:0] val);
    int first[3];
    first = '{0, 0, 0};
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 1) in_valid = 1'b0;
      if (e <= 3) chk({tag, "_count"}, 64'(c2), (e == 3) ? 64'd0 : 64'd1);
      if (ov2 && first[0] == 0) begin first[0] = e; chk({tag, "_d2_data"}, od2, val); end
      if (ov1 && first[1] == 0) begin first[1] = e; chk({tag, "_d1_data"}, od1, val); end
      if (ov4 && first[2] == 0) begin first[2] = e; chk({tag, "_d4_data"}, od4, val); end
    end
    chk({tag, "_d2_latency"}, 64'(first[0]), 64'd2);
    chk({tag, "_d1_latency"}, 64'(first[1]), 64'd1);
    chk({tag, "_d4_latency"}, 64'(first[2]), 64'd4);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int j = 0; j < n; j++) begin @(posedge clk); #1; end
  endtask

  initial begin
    // reset state before any edge
    #30;
    chk("rst_ov2", 64'(ov2), 64'd0);
    chk("rst_od2", od2, 64'd0);
    chk("rst_c2", 64'(c2), 64'd0);
    chk("rst_c4", 64'(c4), 64'd0);
    @(posedge clk); #10;
    reset = 1'b0;

    // 1: single beat latency
    in_valid = 1'b1; in_data = 64'd11970; out_ready = 1'b1;
    measure_latency("t1", 64'd11970);

    // 2: back-to-back stream 1..10
    in_valid = 1'b1; in_data = 64'd1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (j >= 2 && j <= 11) begin
        chk("t2_out_valid", 64'(ov2), 64'd1);
        chk("t2_out_data", od2, 64'(j - 1));
      end
      if (j >= 2 && j <= 10) chk("t2_count", 64'(c2), 64'd2);
      if (j < 10) begin
        in_data = 64'(j + 1);
        chk("t2_in_ready", 64'(ir2), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    idle(4);

    // 3: backpressure then release
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd550;
    @(posedge clk); #1; in_data = 64'd551;
    @(posedge clk); #1; in_data = 64'd552;
    chk("t3_count_full", 64'(c2), 64'd2);
    chk("t3_in_ready_stall", 64'(ir2), 64'd0);
    @(posedge clk); #1;
    chk("t3_in_ready_hold", 64'(ir2), 64'd0);
    chk("t3_head", od2, 64'd550);
    out_ready = 1'b1; #1;
    chk("t3_in_ready_full_eq_out_ready", 64'(ir2), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("t3_second", od2, 64'd551);
    @(posedge clk); #1;
    chk("t3_third", od2, 64'd552);
    @(posedge clk); #1;
    chk("t3_drained", 64'(ov2), 64'd0);
    idle(4);

    // 4: bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd970;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 64'd971;
    chk("t4_no_stall", 64'(ir2), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("t4_count", 64'(c2), 64'd2);
    chk("t4_head", od2, 64'd970);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_b2b_valid", 64'(ov2), 64'd1);
    chk("t4_b2b_data", od2, 64'd971);
    idle(5);

    // 5: full pass-through then flush
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h51;
    @(posedge clk); #1; in_data = 64'h52;
    @(posedge clk); #1;
    in_data = 64'd7; out_ready = 1'b1; #1;
    chk("t5_in_ready_full", 64'(ir2), 64'd1);
    @(posedge clk); #1;
    chk("t5_count_kept", 64'(c2), 64'd2);
    chk("t5_head", od2, 64'h52);
    flush = 1'b1; in_data = 64'd8; #1;
    chk("t5_flush_in_ready", 64'(ir2), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_count", 64'(c2), 64'd0);
    chk("t5_flush_ov", 64'(ov2), 64'd0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk("t5_no_ghost", 64'(ov2 | ov1 | ov4), 64'd0);
    end

    // 6: asynchronous reset mid-stream
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 64'h600 + 64'(j);
      @(posedge clk); #1;
    end
    #29 reset = 1'b1;
    #5;
    chk("t6_ov2", 64'(ov2), 64'd0);
    chk("t6_od2", od2, 64'd0);
    chk("t6_c2", 64'(c2), 64'd0);
    chk("t6_c4", 64'(c4), 64'd0);
    chk("t6_od4", od4, 64'd0);
    @(posedge clk); #10;
    reset = 1'b0; in_valid = 1'b1; in_data = 64'hABC;
    measure_latency("t6", 64'hABC);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
